// File: rtl/booth_ctrl.sv
// Control FSM for the radix-2 Booth multiplier: sequences operand loads, the
// add/sub-then-shift iterations and the completion pulse for the shared datapath.
module booth_ctrl #(
    parameter int N_BITS = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic q0,
    input  logic qm1,
    input  logic eqz,
    output logic ldA,
    output logic clrA,
    output logic sftA,
    output logic ldQ,
    output logic clrQ,
    output logic sftQ,
    output logic ldM,
    output logic clrff,
    output logic ldff,
    output logic addsub,
    output logic ldcnt,
    output logic decr,
    output logic busy,
    output logic done
);

    // The counter is 5 bits wide, so the iteration count must fit in it.
    if (N_BITS < 1 || N_BITS > 31) begin : g_bad_width
        $error("booth_ctrl: N_BITS must be in 1..31");
    end

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_LOAD_M = 4'd1;
    localparam logic [3:0] S_LOAD_Q = 4'd2;
    localparam logic [3:0] S_CHECK  = 4'd3;
    localparam logic [3:0] S_ADD    = 4'd4;
    localparam logic [3:0] S_SUB    = 4'd5;
    localparam logic [3:0] S_SHIFT  = 4'd6;
    localparam logic [3:0] S_DONE   = 4'd7;

    logic [3:0] state;
    logic [3:0] state_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Counter exhaustion takes priority over the Booth pair decode.
    always_comb begin
        state_nxt = S_IDLE;
        case (state)
            S_IDLE:   state_nxt = start ? S_LOAD_M : S_IDLE;
            S_LOAD_M: state_nxt = S_LOAD_Q;
            S_LOAD_Q: state_nxt = S_CHECK;
            S_CHECK: begin
                if (eqz) begin
                    state_nxt = S_DONE;
                end else if (q0 && !qm1) begin
                    state_nxt = S_SUB;
                end else if (!q0 && qm1) begin
                    state_nxt = S_ADD;
                end else begin
                    state_nxt = S_SHIFT;
                end
            end
            S_ADD:    state_nxt = S_SHIFT;
            S_SUB:    state_nxt = S_SHIFT;
            S_SHIFT:  state_nxt = S_CHECK;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        ldA    = 1'b0;
        clrA   = 1'b0;
        sftA   = 1'b0;
        ldQ    = 1'b0;
        clrQ   = 1'b0;
        sftQ   = 1'b0;
        ldM    = 1'b0;
        clrff  = 1'b0;
        ldff   = 1'b0;
        addsub = 1'b0;
        ldcnt  = 1'b0;
        decr   = 1'b0;
        busy   = 1'b1;
        done   = 1'b0;
        case (state)
            S_IDLE: busy = 1'b0;
            S_LOAD_M: begin
                ldM   = 1'b1;
                clrA  = 1'b1;
                clrff = 1'b1;
            end
            S_LOAD_Q: begin
                ldQ   = 1'b1;
                ldcnt = 1'b1;
            end
            S_CHECK: ;
            S_ADD: begin
                ldA    = 1'b1;
                addsub = 1'b1;
            end
            S_SUB: ldA = 1'b1;
            S_SHIFT: begin
                sftA = 1'b1;
                sftQ = 1'b1;
                ldff = 1'b1;
                decr = 1'b1;
            end
            S_DONE: done = 1'b1;
            default: busy = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_booth_ctrl.sv
// Bench for booth_ctrl: a behavioural Booth datapath closes the loop so products,
// latency, strobe counts and reset/start corner cases are checked against hand values.
module tb_booth_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic q0, qm1, eqz;
    logic ldA, clrA, sftA, ldQ, clrQ, sftQ, ldM, clrff, ldff, addsub, ldcnt, decr, busy, done;

    logic [15:0] mbus = 16'h0;
    logic [15:0] qbus = 16'h0;

    bit [15:0] a_r, q_r, m_r;
    bit        qm1_r;
    bit [4:0]  cnt;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    booth_ctrl #(.N_BITS(16)) dut (
        .clk(clk), .rst(rst), .start(start), .q0(q0), .qm1(qm1), .eqz(eqz),
        .ldA(ldA), .clrA(clrA), .sftA(sftA), .ldQ(ldQ), .clrQ(clrQ), .sftQ(sftQ),
        .ldM(ldM), .clrff(clrff), .ldff(ldff), .addsub(addsub), .ldcnt(ldcnt),
        .decr(decr), .busy(busy), .done(done)
    );

    // Behavioural datapath: A/Q/M registers, Q[-1] flop and iteration counter.
    always @(posedge clk) begin
        if (ldM)   m_r <= mbus;
        if (clrA)  a_r <= 16'h0;
        if (clrff) qm1_r <= 1'b0;
        if (ldQ)   q_r <= qbus;
        if (ldcnt) cnt <= 5'd16;
        if (ldA)   a_r <= addsub ? a_r + m_r : a_r - m_r;
        if (sftA)  a_r <= {a_r[15], a_r[15:1]};
        if (sftQ)  q_r <= {a_r[0], q_r[15:1]};
        if (ldff)  qm1_r <= q_r[0];
        if (decr)  cnt <= cnt - 5'd1;
    end

    assign q0  = q_r[0];
    assign qm1 = qm1_r;
    assign eqz = (cnt == 5'd0);

    wire [13:0] outs = {ldA, clrA, sftA, ldQ, clrQ, sftQ, ldM, clrff, ldff,
                        addsub, ldcnt, decr, busy, done};

    typedef struct {
        logic [15:0] m;
        logic [15:0] q;
        int          k;
        logic [31:0] prod;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    // One multiply: launch, then watch strobes every cycle until back in IDLE.
    task automatic run_mul(input logic [15:0] m, input logic [15:0] q, input int k,
                           input logic [31:0] prod, input bit poke, input bit hold,
                           input string name);
        int busy_cnt = 0, done_cnt = 0, decr_cnt = 0, lda_cnt = 0, shift_cnt = 0;
        int done_edge = -1;
        bit finished = 0;
        @(negedge clk);
        mbus = m;
        qbus = q;
        start = 1'b1;
        for (int cyc = 0; cyc < 200; cyc++) begin
            @(posedge clk);
            #1;
            if (cyc == 0) check({name, "_accept"}, {30'd0, ldM, busy}, 32'd3);
            if (sftA) shift_cnt++;
            if (!hold) start = poke && (ldQ || (sftA && shift_cnt == 3));
            if (busy) busy_cnt++;
            if (decr) decr_cnt++;
            if (ldA)  lda_cnt++;
            if (done) begin
                done_cnt++;
                if (done_edge < 0) done_edge = cyc + 1;
            end
            if (!busy) begin
                finished = 1;
                break;
            end
        end
        check({name, "_finished"}, 32'(finished), 32'd1);
        check({name, "_done_edge"}, 32'(done_edge), 32'(36 + k));
        check({name, "_busy_cycles"}, 32'(busy_cnt), 32'(36 + k));
        check({name, "_done_width"}, 32'(done_cnt), 32'd1);
        check({name, "_decr_count"}, 32'(decr_cnt), 32'd16);
        check({name, "_addsub_visits"}, 32'(lda_cnt), 32'(k));
        check({name, "_product"}, {a_r, q_r}, prod);
    endtask

    initial begin
        bit seen;
        vecs[0] = '{m: 16'h1234, q: 16'h0000, k: 0,  prod: 32'h0000_0000};
        vecs[1] = '{m: 16'h0003, q: 16'hFFFF, k: 1,  prod: 32'hFFFF_FFFD};
        vecs[2] = '{m: 16'h0007, q: 16'h5555, k: 16, prod: 32'h0002_5553};
        vecs[3] = '{m: 16'h0003, q: 16'h0005, k: 4,  prod: 32'h0000_000F};
        vecs[4] = '{m: 16'h0005, q: 16'hFFFB, k: 3,  prod: 32'hFFFF_FFE7};
        vecs[5] = '{m: 16'h7FFF, q: 16'h7FFF, k: 2,  prod: 32'h3FFF_0001};

        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", 32'(outs), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("idle_outputs", 32'(outs), 32'd0);

        // Reset while in SUB: abort immediately, no completion afterwards.
        @(negedge clk);
        mbus = 16'h0003;
        qbus = 16'h0001;
        start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("in_sub_state", {30'd0, ldA, addsub}, 32'd2);
        #1 rst = 1'b1;
        #1 check("async_reset_outputs", 32'(outs), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (50) begin
            @(posedge clk); #1;
            if (done || busy) seen = 1;
        end
        check("no_done_after_abort", 32'(seen), 32'd0);
        run_mul(16'h0003, 16'h0005, 4, 32'h0000_000F, 0, 0, "after_reset");

        for (int i = 0; i < 6; i++) begin
            run_mul(vecs[i].m, vecs[i].q, vecs[i].k, vecs[i].prod, 0, 0, $sformatf("vec%0d", i));
        end

        // start pulsed in LOAD_Q and in a SHIFT must not disturb the sequence.
        run_mul(16'h0007, 16'h5555, 16, 32'h0002_5553, 1, 0, "start_poke");

        // start held high: back-to-back multiplies with a single IDLE gap.
        run_mul(16'hFFFE, 16'hFFFD, 3, 32'h0000_0006, 0, 1, "held_first");
        run_mul(16'h7FFF, 16'h7FFF, 2, 32'h3FFF_0001, 0, 1, "held_second");
        start = 1'b0;
        @(posedge clk); #1;
        check("idle_after_release", 32'(outs), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
